// File: rtl/kd_tree_wb_loader_pkg.sv
// Shared KD-tree constants and the loader FSM state encoding.
package kd_tree_wb_loader_pkg;

  // Node word is {hi, lo}, two 11-bit halves.
  localparam int INTERNAL_WIDTH    = 22;
  localparam int HALF_W            = 11;
  // Bit of the Wishbone data word that selects the hi (1) or lo (0) half.
  localparam int HALF_SEL_BIT      = 11;
  // Wishbone base address of the tree's node storage.
  localparam int WB_ADDRESS_OFFSET = 495;
  // Internal nodes, stored in BFS order.
  localparam int NUM_NODES         = 63;
  localparam int CNT_W             = 6;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_WR_LO  = 4'd2,
    ST_WR_HI  = 4'd3,
    ST_RD_LO  = 4'd4,
    ST_RD_HI  = 4'd5,
    ST_RD_OUT = 4'd6,
    ST_FINISH = 4'd7,
    ST_FAULT  = 4'd8
  } loader_state_e;

endpackage

// File: rtl/kd_tree_wb_loader.sv
// Loads (mode 0) or reads back (mode 1) all KD-tree node words over Wishbone,
// two 11-bit halves per node. The target does not ack the lo-half write; every
// other access waits for ack, bounded by TIMEOUT cycles.
//
// Handshakes: node_valid/node_ready and rd_valid/rd_ready transfer one word on
// any clock edge where both are 1; the producer holds its data stable while
// valid is high and ready is low.
module kd_tree_wb_loader
  import kd_tree_wb_loader_pkg::*;
#(
  parameter int INTERNAL_WIDTH    = kd_tree_wb_loader_pkg::INTERNAL_WIDTH,
  parameter int WB_ADDRESS_OFFSET = kd_tree_wb_loader_pkg::WB_ADDRESS_OFFSET,
  parameter int NUM_NODES         = kd_tree_wb_loader_pkg::NUM_NODES,
  parameter int TIMEOUT           = 15
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      start,
  input  logic                      mode,
  input  logic                      node_valid,
  output logic                      node_ready,
  input  logic [INTERNAL_WIDTH-1:0] node_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [INTERNAL_WIDTH-1:0] rd_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      wb_mode_o,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [3:0]                wbm_sel_o,
  output logic [31:0]               wbm_adr_o,
  output logic [31:0]               wbm_dat_o,
  input  logic [31:0]               wbm_dat_i,
  input  logic                      wbm_ack_i
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NODES - 1);

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [HALF_W-1:0] lo_q, lo_d;
  logic [HALF_W-1:0] hi_q, hi_d;
  logic              err_q, err_d;

  logic              tmo_hit;
  logic [31:0]       node_adr;

  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT));
  assign node_adr = 32'(WB_ADDRESS_OFFSET) + 32'(cnt_q);

  // State, node counter, ack-wait counter, half buffers and sticky error.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  // Next-state and output decode; the ack-wait counter falls back to 0
  // unless a wait state is still waiting, so every wait starts from 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = '0;
    lo_d       = lo_q;
    hi_d       = hi_q;
    err_d      = err_q;
    node_ready = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    done       = 1'b0;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_sel_o  = 4'h0;
    wbm_adr_o  = '0;
    wbm_dat_o  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = mode ? ST_RD_LO : ST_FETCH;
        end
      end

      ST_FETCH: begin
        node_ready = 1'b1;
        if (node_valid) begin
          lo_d    = node_data[HALF_W-1:0];
          hi_d    = node_data[2*HALF_W-1:HALF_W];
          state_d = ST_WR_LO;
        end
      end

      ST_WR_LO: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = node_adr;
        wbm_dat_o = 32'({1'b0, lo_q});
        state_d   = ST_WR_HI;
      end

      ST_WR_HI: begin
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_FAULT;
        end else begin
          wbm_cyc_o = 1'b1;
          wbm_stb_o = 1'b1;
          wbm_we_o  = 1'b1;
          wbm_sel_o = 4'hF;
          wbm_adr_o = node_adr;
          wbm_dat_o = 32'({1'b1, hi_q});
          if (wbm_ack_i) begin
            if (cnt_q == LAST_CNT) begin
              state_d = ST_FINISH;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = ST_FETCH;
            end
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      ST_RD_LO, ST_RD_HI: begin
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_FAULT;
        end else begin
          wbm_cyc_o = 1'b1;
          wbm_stb_o = 1'b1;
          wbm_sel_o = 4'hF;
          wbm_adr_o = node_adr;
          wbm_dat_o[HALF_SEL_BIT] = (state_q == ST_RD_HI);
          if (wbm_ack_i) begin
            if (state_q == ST_RD_LO) begin
              lo_d    = wbm_dat_i[HALF_W-1:0];
              state_d = ST_RD_HI;
            end else begin
              hi_d    = wbm_dat_i[HALF_W-1:0];
              state_d = ST_RD_OUT;
            end
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      ST_RD_OUT: begin
        rd_valid = 1'b1;
        rd_data  = {hi_q, lo_q};
        if (rd_ready) begin
          if (cnt_q == LAST_CNT) begin
            state_d = ST_FINISH;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_RD_LO;
          end
        end
      end

      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign wb_mode_o = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_kd_tree_wb_loader.sv
// Directed bench for kd_tree_wb_loader: a Wishbone tree model, node feeder,
// read-back consumer and a bus-beat scoreboard.
module tb_kd_tree_wb_loader;

  localparam int NN   = 63;
  localparam int BASE = 495;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic        node_valid;
  logic        node_ready;
  logic [21:0] node_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [21:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        wb_mode_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  kd_tree_wb_loader dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start      (start),
    .mode       (mode),
    .node_valid (node_valid),
    .node_ready (node_ready),
    .node_data  (node_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .wb_mode_o  (wb_mode_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- Wishbone tree model ----------------
  logic [10:0] lo_mem [NN];
  logic [10:0] hi_mem [NN];
  int          withhold_idx = -1;
  logic        spurious = 1'b0;
  logic [31:0] idx;
  logic        in_range;

  assign idx      = wbm_adr_o - 32'(BASE);
  assign in_range = (idx < 32'(NN));

  // Zero-latency ack on hi writes and on reads; the lo write is never acked.
  always_comb begin
    wbm_ack_i = spurious;
    wbm_dat_i = 32'hDEAD_BEEF;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (wbm_we_o) begin
        if (wbm_dat_o[11] && (int'(idx) != withhold_idx)) wbm_ack_i = 1'b1;
      end else begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = {21'h1A5A5A, 11'h000};
        if (in_range) wbm_dat_i[10:0] = wbm_dat_o[11] ? hi_mem[idx[5:0]] : lo_mem[idx[5:0]];
      end
    end
  end

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && wbm_we_o && in_range) begin
      if (wbm_dat_o[11] && wbm_ack_i) hi_mem[idx[5:0]] <= wbm_dat_o[10:0];
      if (!wbm_dat_o[11])             lo_mem[idx[5:0]] <= wbm_dat_o[10:0];
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [68:0] exp_q[$];
  logic        mon_en   = 1'b0;
  int          done_cnt = 0;
  int          hold_cnt = 0;
  int          bus_viol = 0;
  int          stab_viol = 0;

  function automatic logic [68:0] beat(input logic we, input int k, input logic [31:0] dat);
    logic [31:0] adr;
    adr = 32'(BASE + k);
    return {we, 4'hF, adr, dat};
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wbm_cyc_o && wbm_stb_o && wbm_we_o && wbm_dat_o[11] && (int'(idx) == withhold_idx))
      hold_cnt++;
    if ((node_ready || rd_valid) && (wbm_cyc_o || wbm_stb_o || wbm_we_o)) bus_viol++;
    if (mon_en && wbm_cyc_o && wbm_stb_o) begin
      if (exp_q.size() == 0)
        check_eq("wb_extra_beat", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, '0);
      else
        check_eq("wb_beat", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] all_outputs();
    return 128'({err, done, busy, wb_mode_o, node_ready, rd_valid, rd_data,
                 wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o});
  endfunction

  task automatic start_pass(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b0;
  endtask

  task automatic push_write_beats();
    for (int k = 0; k < NN; k++) begin
      exp_q.push_back(beat(1'b1, k, 32'(k)));
      exp_q.push_back(beat(1'b1, k, 32'h800 | 32'(k + 100)));
    end
  endtask

  task automatic push_read_beats();
    for (int k = 0; k < NN; k++) begin
      exp_q.push_back(beat(1'b0, k, 32'h000));
      exp_q.push_back(beat(1'b0, k, 32'h800));
    end
  endtask

  // Feeds words 0..count-1; inj selects the word after which a stray start
  // pulse is driven during the gap.
  task automatic feed(input int count, input int gap, input int inj);
    for (int k = 0; k < count; k++) begin
      int n;
      n = 0;
      node_data  = {11'(k + 100), 11'(k)};
      node_valid = 1'b1;
      while (!node_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!node_ready) begin
        check_eq("node_ready_timeout", 128'(node_ready), 128'(1));
        node_valid = 1'b0;
        return;
      end
      @(negedge clk);
      node_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        start = (k == inj) && (g == 0);
        mode  = 1'b1;
        @(negedge clk);
      end
      start = 1'b0;
      mode  = 1'b0;
    end
  endtask

  task automatic read_beats(input int stall);
    for (int k = 0; k < NN; k++) begin
      int          n;
      logic [21:0] first;
      n = 0;
      while (!rd_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!rd_valid) begin
        check_eq("rd_valid_timeout", 128'(rd_valid), 128'(1));
        return;
      end
      first = rd_data;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (rd_data !== first || !rd_valid) stab_viol++;
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      check_eq("rd_data", 128'(first), 128'({11'(k + 100), 11'(k)}));
    end
  endtask

  task automatic check_tree(input string tag);
    int mism;
    mism = 0;
    for (int k = 0; k < NN; k++)
      if (lo_mem[k] !== 11'(k) || hi_mem[k] !== 11'(k + 100)) mism++;
    check_eq(tag, 128'(mism), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    node_valid = 1'b0; node_data = '0; rd_ready = 1'b0;
    for (int k = 0; k < NN; k++) begin
      lo_mem[k] = '0;
      hi_mem[k] = '0;
    end
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_outputs(), '0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_outputs", all_outputs(), '0);

    // Write pass, zero-latency ack.
    push_write_beats();
    mon_en = 1'b1;
    done_cnt = 0;
    start_pass(1'b0);
    check_eq("write_busy_mode", 128'({busy, wb_mode_o}), 128'(2'b11));
    feed(NN, 0, -1);
    repeat (5) @(negedge clk);
    check_eq("write_done_pulses", 128'(done_cnt), 128'(1));
    check_eq("write_err", 128'(err), 128'(0));
    check_eq("write_beats_left", 128'(exp_q.size()), 128'(0));
    check_eq("write_idle", 128'(busy), 128'(0));
    check_tree("tree_after_write");

    // Read-back pass.
    push_read_beats();
    done_cnt = 0;
    start_pass(1'b1);
    read_beats(0);
    repeat (5) @(negedge clk);
    check_eq("read_done_pulses", 128'(done_cnt), 128'(1));
    check_eq("read_beats_left", 128'(exp_q.size()), 128'(0));

    // Gapped write with stray acks and a stray start, then stalled read.
    push_write_beats();
    done_cnt = 0;
    spurious = 1'b1;
    start_pass(1'b0);
    feed(NN, 3, 10);
    repeat (5) @(negedge clk);
    spurious = 1'b0;
    check_eq("gap_write_done", 128'(done_cnt), 128'(1));
    check_eq("gap_write_beats_left", 128'(exp_q.size()), 128'(0));
    check_tree("tree_after_gap_write");
    push_read_beats();
    done_cnt = 0;
    start_pass(1'b1);
    read_beats(4);
    repeat (5) @(negedge clk);
    check_eq("stall_read_done", 128'(done_cnt), 128'(1));
    check_eq("rd_data_stable", 128'(stab_viol), 128'(0));
    check_eq("bus_quiet_in_handshake", 128'(bus_viol), 128'(0));

    // Ack withheld on node 5 hi half.
    mon_en = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    hold_cnt = 0;
    withhold_idx = 5;
    start_pass(1'b0);
    feed(6, 0, -1);
    begin
      int n;
      n = 0;
      while (!err && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("timeout_err", 128'(err), 128'(1));
    check_eq("timeout_stb_cycles", 128'(hold_cnt), 128'(15));
    @(negedge clk);
    check_eq("timeout_back_idle", 128'({busy, wbm_cyc_o, wbm_stb_o}), 128'(0));
    check_eq("timeout_err_sticky", 128'(err), 128'(1));
    check_eq("timeout_no_done", 128'(done_cnt), 128'(0));
    withhold_idx = -1;
    start_pass(1'b1);
    check_eq("start_clears_err", 128'({err, busy}), 128'(2'b01));

    // Reset in node 30 hi write.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    withhold_idx = 30;
    start_pass(1'b0);
    feed(31, 0, -1);
    repeat (2) @(negedge clk);
    check_eq("stuck_in_wr_hi", 128'({wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o[11]}),
             128'({1'b1, 1'b1, 32'(BASE + 30), 1'b1}));
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_reset_outputs", all_outputs(), '0);
    @(negedge clk);
    rst = 1'b0;
    withhold_idx = -1;
    repeat (2) @(negedge clk);
    check_eq("reset_no_done", 128'(done_cnt), 128'(0));
    check_eq("post_reset_idle", all_outputs(), '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $finish;
  end

endmodule

// File: doc/kd_tree_wb_loader.md
KD_TREE_WB_LOADER -- requirements
Module: kd_tree_wb_loader

Interface
REQ-001 SHALL have parameters: INTERNAL_WIDTH 22 (node word, {hi[10:0],lo[10:0]}); WB_ADDRESS_OFFSET 495 (target base address); NUM_NODES 63 (internal nodes, BFS order); TIMEOUT 15 (ack-wait cycles).
REQ-002 SHALL have ports, clock and reset first:
 wb_clk_i in 1 -- sole clock
 wb_rst_i in 1 -- asynchronous, active-high reset
 start in 1 -- begin a pass, sampled in IDLE only
 mode in 1 -- 0 write tree, 1 read back tree; latched on start
 node_valid in 1 / node_ready out 1 / node_data in 22 -- write-data stream
 rd_valid out 1 / rd_ready in 1 / rd_data out 22 -- read-back stream
 busy out 1 -- pass in progress
 done out 1 -- one-cycle pass-complete pulse
 err out 1 -- sticky ack-timeout flag
 wb_mode_o out 1 -- drives the tree's wb_mode
 wbm_cyc_o, wbm_stb_o, wbm_we_o out 1 each; wbm_sel_o out 4; wbm_adr_o out 32; wbm_dat_o out 32
 wbm_dat_i in 32; wbm_ack_i in 1

Function
REQ-003 SHALL implement FSM states IDLE, FETCH, WR_LO, WR_HI, RD_LO, RD_HI, RD_OUT, FINISH, FAULT.
REQ-004 IDLE: on start, SHALL clear err and node counter cnt (6 bits), then go to FETCH (mode 0) or RD_LO (mode 1); start SHALL be ignored in every other state.
REQ-005 FETCH: node_ready SHALL be 1; on node_valid, node_data SHALL be latched and the FSM SHALL enter WR_LO the next cycle.
REQ-006 WR_LO: cyc=stb=we=1 for exactly one cycle; adr=WB_ADDRESS_OFFSET+cnt; dat={20'b0,1'b0,lo}; no ack awaited (target does not ack low half); next state WR_HI.
REQ-007 WR_HI: cyc=stb=we=1, same adr, dat={20'b0,1'b1,hi}; held until wbm_ack_i; on ack, FINISH if cnt==NUM_NODES-1, else cnt+1 and FETCH.
REQ-008 RD_LO / RD_HI: cyc=stb=1, we=0, adr=WB_ADDRESS_OFFSET+cnt, dat bit 11 = 0 / 1 (half select), other dat bits 0; on ack capture wbm_dat_i[10:0] into lo / hi and advance to RD_HI / RD_OUT.
REQ-009 RD_OUT: rd_valid=1, rd_data={hi,lo}, stable until rd_ready; on rd_ready, FINISH if cnt==NUM_NODES-1, else cnt+1 and RD_LO.
REQ-010 Address SHALL be computed as a 32-bit unsigned sum; cnt SHALL never wrap past NUM_NODES-1.
REQ-011 wbm_sel_o SHALL be 4'hF whenever stb=1; cyc, stb and we SHALL be 0 in IDLE, FETCH, RD_OUT, FINISH, FAULT.
REQ-012 Ack-wait counter SHALL reload to 0 on entry to WR_HI, RD_LO, RD_HI; if it reaches TIMEOUT with no ack, the FSM SHALL enter FAULT, dropping cyc/stb the same cycle.
REQ-013 FAULT: err SHALL set (held until next start); FSM SHALL return to IDLE the next cycle; done SHALL not pulse.
REQ-014 FINISH: done=1 for one cycle; next state IDLE.
REQ-015 busy and wb_mode_o SHALL be 1 in every state except IDLE.
REQ-016 ack arriving in a state not awaiting ack SHALL be ignored.

Reset
REQ-017 wb_rst_i SHALL asynchronously force IDLE, cnt=0, timeout counter 0, lo/hi=0, and all outputs 0 (err, done, busy, wb_mode_o, node_ready, rd_valid, rd_data, all wbm_* outputs).
REQ-018 Reset asserted mid-pass SHALL abort the pass with no done pulse; the tree's partial contents are unaffected by the loader.

Structure
REQ-019 INTERNAL_WIDTH, half width 11, half-select bit index 11, WB_ADDRESS_OFFSET and NUM_NODES SHALL live in the shared KD-tree package, with the FSM state enum.
REQ-020 Single module; no sub-modules (timeout counter inline).

Verification
REQ-021 Write pass: 63 words, word k = {11'(k+100),11'(k)}, zero-latency ack on hi -> addresses 495..557, lo dat 0x000+k, hi dat 0x800+(k+100), one done pulse, err=0.
REQ-022 Read-back against the tree model after REQ-021 -> rd_data for k equals {k+100,k}, 63 beats, done pulse.
REQ-023 Ack withheld on node 5 hi half -> FAULT after 15 cycles, cyc drops, err=1, no done; next start clears err.
REQ-024 node_valid gapped 3 cycles between words, rd_ready held low 4 cycles per beat -> no Wishbone activity during gaps, rd_data stable, results as REQ-021/022.
REQ-025 wb_rst_i asserted at node 30 WR_HI -> all outputs 0 within the same cycle; start issued during a pass ignored.
